instr_mem_loader: RTL and testbench

Byte-wide instruction memory with a word-stream write port and a word fetch port. Accepts 32-bit instruction words over a valid/ready handshake, splits each into four bytes (big-endian, MSB at lowest address) and writes them one byte per cycle at sequential byte addresses from 0. The fetch stage reads the same memory as four consecutive bytes starting at a byte-aligned `pc`. The block therefore replaces the file-initialised instruction memory with a run-time programmable one.

---
 rtl/instr_mem_loader.sv | 153 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Run-time programmable byte-wide instruction memory: 32-bit words stream in big-endian,
// one byte per cycle; fetch returns four bytes at pc. Optional checksum via LOADER_CHECKSUM_EN.
module instr_mem_loader #(
   parameter int DEPTH_BYTES = 64,
   parameter int ADDR_W      = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_word,
   input  logic              in_last,
   input  logic [31:0]       fetch_addr,
   output logic [31:0]       fetch_instr,
   output logic              busy,
   output logic              done,
   output logic              overflow,
`ifdef LOADER_CHECKSUM_EN
   output logic [31:0]       checksum,
`endif
   output logic [ADDR_W-2:0] word_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   // wr_addr carries one extra bit so a full memory (DEPTH_BYTES) is representable without wrapping
   localparam logic [ADDR_W:0] LAST_WORD_ADDR = (ADDR_W+1)'(DEPTH_BYTES - 4);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
   logic [1:0]        bc_q, bc_d;
   logic [31:0]       shreg_q, shreg_d;
   logic              last_q, last_d;
   logic [ADDR_W-2:0] wc_q, wc_d;
   logic [31:0]       fetch_q, fetch_d;
   logic [31:0]       fidx_s;
   logic              mem_we_s;
   logic [7:0]        mem_q [DEPTH_BYTES];
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]       cks_q, cks_d;
`endif

   // State, address, shift register and fetch output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wr_addr_q <= '0;
         bc_q      <= 2'd0;
         shreg_q   <= 32'd0;
         last_q    <= 1'b0;
         wc_q      <= '0;
         fetch_q   <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         cks_q     <= 32'd0;
`endif
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         bc_q      <= bc_d;
         shreg_q   <= shreg_d;
         last_q    <= last_d;
         wc_q      <= wc_d;
         fetch_q   <= fetch_d;
`ifdef LOADER_CHECKSUM_EN
         cks_q     <= cks_d;
`endif
      end
   end

   // Byte array is deliberately left out of reset so a loaded program survives rst
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[wr_addr_q[ADDR_W-1:0]] <= shreg_q[31:24];
      end
   end

   // Loader FSM next state
   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      bc_d      = bc_q;
      shreg_d   = shreg_q;
      last_d    = last_q;
      wc_d      = wc_q;
`ifdef LOADER_CHECKSUM_EN
      cks_d     = cks_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (wr_addr_q <= LAST_WORD_ADDR) begin
                  state_d = S_WR;
                  shreg_d = in_word;
                  last_d  = in_last;
                  bc_d    = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                  cks_d   = cks_q ^ in_word;
`endif
               end else begin
                  state_d = S_ERR;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR: begin
            shreg_d   = {shreg_q[23:0], 8'h00};
            wr_addr_d = wr_addr_q + (ADDR_W+1)'(1);
            bc_d      = bc_q + 2'd1;
            if (bc_q == 2'd3) begin
               wc_d    = wc_q + (ADDR_W-1)'(1);
               state_d = last_q ? S_DONE : S_IDLE;
            end else begin
               state_d = S_WR;
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

   // Fetch: out-of-range bytes read as zero; the index sum is taken at full 32 bits
   always_comb begin
      fetch_d = 32'd0;
      fidx_s  = 32'd0;
      for (int k = 0; k < 4; k++) begin
         fidx_s = fetch_addr + 32'(k);
         if (fidx_s < 32'(DEPTH_BYTES)) begin
            fetch_d[31-8*k -: 8] = mem_q[fidx_s[ADDR_W-1:0]];
         end else begin
            fetch_d[31-8*k -: 8] = 8'h00;
         end
      end
   end

   assign mem_we_s    = (state_q == S_WR) && !rst;
   assign in_ready    = (state_q == S_IDLE);
   assign busy        = (state_q == S_WR);
   assign done        = (state_q == S_DONE);
   assign overflow    = (state_q == S_ERR);
   assign word_count  = wc_q;
   assign fetch_instr = fetch_q;
`ifdef LOADER_CHECKSUM_EN
   assign checksum    = cks_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader against a queue-based behavioural model.
module tb_instr_mem_loader;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_word;
   logic          in_last;
   logic [31:0]   fetch_addr;
   logic [31:0]   fetch_instr;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [AW-2:0] word_count;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   instr_mem_loader #(.DEPTH_BYTES(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_word(in_word), .in_last(in_last), .fetch_addr(fetch_addr),
      .fetch_instr(fetch_instr), .busy(busy), .done(done), .overflow(overflow),
`ifdef LOADER_CHECKSUM_EN
      .checksum(checksum),
`endif
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // behavioural model
   logic [7:0]  m_mem [DEPTH];
   logic [7:0]  m_q [$];
   int          m_wr, m_left, m_wc;
   bit          m_last, m_done, m_ovf, m_accepted;
   logic [31:0] m_cks, m_fetch;

   function automatic logic [31:0] model_fetch(input logic [31:0] a);
      logic [31:0] r, i;
      r = 32'd0;
      for (int k = 0; k < 4; k++) begin
         i = a + 32'(k);
         r = {r[23:0], (i < DEPTH) ? m_mem[i] : 8'h00};
      end
      return r;
   endfunction

   function automatic bit m_ready();
      return !m_done && !m_ovf && (m_left == 0);
   endfunction

   task tick();
      logic [31:0] nf;
      m_accepted = 1'b0;
      nf = model_fetch(fetch_addr);
      if (rst) begin
         m_wr = 0; m_left = 0; m_wc = 0; m_last = 0; m_done = 0; m_ovf = 0;
         m_cks = 32'd0; m_q.delete(); nf = 32'd0;
      end else if (m_left > 0) begin
         m_mem[m_wr] = m_q.pop_front();
         m_wr++;
         m_left--;
         if (m_left == 0) begin
            m_wc++;
            if (m_last) m_done = 1;
         end
      end else if (m_ready() && in_valid) begin
         m_accepted = 1'b1;
         if (m_wr + 4 <= DEPTH) begin
            for (int k = 0; k < 4; k++) m_q.push_back(in_word[31-8*k -: 8]);
            m_left = 4;
            m_last = in_last;
            m_cks  = m_cks ^ in_word;
         end else begin
            m_ovf = 1;
         end
      end
      @(posedge clk);
      #1;
      m_fetch = nf;
   endtask

   task do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task put_word(input logic [31:0] w, input logic l);
      int n;
      in_valid = 1'b1; in_word = w; in_last = l; n = 0;
      do begin
         vectors++;
         if (in_ready !== m_ready()) begin
            miscompares++;
            $display("FAIL put_word.in_ready got %0b want %0b", in_ready, m_ready());
         end
         tick();
         n++;
      end while (!m_accepted && n < 20);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task drain();
      while (m_left > 0) tick();
   endtask

   task test_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_word = 32'd0; fetch_addr = 32'd100;
      m_wr = 0; m_left = 0; m_wc = 0; m_cks = 32'd0;
      tick(); tick();
      rst = 1'b0;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset.in_ready got %0b want 1", in_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset.busy got %0b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset.done got %0b want 0", done); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset.overflow got %0b want 0", overflow); end
      vectors++; if (word_count !== 5'd0) begin miscompares++; $display("FAIL reset.word_count got %0d want 0", word_count); end
      vectors++; if (fetch_instr !== 32'd0) begin miscompares++; $display("FAIL reset.fetch got %h want 0", fetch_instr); end
`ifdef LOADER_CHECKSUM_EN
      vectors++; if (checksum !== 32'd0) begin miscompares++; $display("FAIL reset.checksum got %h want 0", checksum); end
`endif
   endtask

   task test_overflow();
      logic [31:0] w;
      for (int i = 0; i < 16; i++) begin
         w = (i == 1 || i == 15) ? 32'd0 : $urandom;
         put_word(w, 1'b0);
      end
      drain();
      vectors++; if (word_count !== 5'd16) begin miscompares++; $display("FAIL ovf.word_count got %0d want 16", word_count); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ovf.ready_before got %0b want 1", in_ready); end
      put_word($urandom, 1'b1);
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf.overflow got %0b want 1", overflow); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ovf.in_ready got %0b want 0", in_ready); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL ovf.done got %0b want 0", done); end
      fetch_addr = 32'd60;
      tick(); tick();
      vectors++; if (fetch_instr !== 32'd0 || fetch_instr !== m_fetch) begin miscompares++; $display("FAIL ovf.mem60 got %h want %h", fetch_instr, m_fetch); end
      vectors++; if (word_count !== 5'd16) begin miscompares++; $display("FAIL ovf.word_count_after got %0d want 16", word_count); end
      vectors++; if (overflow !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL ovf.sticky got ovf=%0b rdy=%0b want 1/0", overflow, in_ready); end
   endtask

   task test_single();
      do_reset();
      put_word(32'h8C220004, 1'b1);
      drain();
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL single.done got %0b want 1", done); end
      vectors++; if (word_count !== 5'd1) begin miscompares++; $display("FAIL single.word_count got %0d want 1", word_count); end
      fetch_addr = 32'd1;
      tick();
      vectors++; if (fetch_instr !== 32'h22000400) begin miscompares++; $display("FAIL single.fetch1 got %h want 22000400", fetch_instr); end
      fetch_addr = 32'd62;
      tick();
      vectors++; if (fetch_instr !== 32'h00000000) begin miscompares++; $display("FAIL single.fetch62 got %h want 00000000", fetch_instr); end
   endtask

   task test_program();
      logic [31:0] prog [3];
      prog[0] = 32'h2002000A; prog[1] = 32'h20030005; prog[2] = 32'h00432020;
      do_reset();
      put_word(prog[0], 1'b0);
      put_word(prog[1], 1'b0);
      put_word(prog[2], 1'b1);
      tick(); tick(); tick();
      vectors++; if (done !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL prog.before_last got done=%0b busy=%0b want 0/1", done, busy); end
      tick();
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL prog.done got %0b want 1", done); end
      vectors++; if (word_count !== 5'd3) begin miscompares++; $display("FAIL prog.word_count got %0d want 3", word_count); end
      vectors++; if (in_ready !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL prog.idle got rdy=%0b busy=%0b want 0/0", in_ready, busy); end
      for (int i = 0; i < 3; i++) begin
         fetch_addr = 32'(4*i);
         tick();
         vectors++;
         if (fetch_instr !== prog[i]) begin miscompares++; $display("FAIL prog.fetch%0d got %h want %h", 4*i, fetch_instr, prog[i]); end
      end
   endtask

   task test_back_to_back();
      int pulses, prev, bad;
      do_reset();
      pulses = 0; prev = -1; bad = 0;
      in_valid = 1'b1; in_last = 1'b0;
      for (int c = 0; c < 40; c++) begin
         in_word = $urandom;
         vectors++;
         if (in_ready !== m_ready()) begin miscompares++; $display("FAIL b2b.in_ready cyc %0d got %0b want %0b", c, in_ready, m_ready()); end
         if (in_ready === 1'b1) begin
            pulses++;
            if (prev >= 0 && c - prev != 5) bad++;
            prev = c;
         end
         tick();
      end
      in_valid = 1'b0;
      vectors++; if (pulses != 8) begin miscompares++; $display("FAIL b2b.pulses got %0d want 8", pulses); end
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL b2b.spacing got %0d bad gaps want 0", bad); end
      vectors++; if (word_count !== 5'd8 || int'(word_count) != m_wc) begin miscompares++; $display("FAIL b2b.word_count got %0d want 8", word_count); end
`ifdef LOADER_CHECKSUM_EN
      vectors++; if (checksum !== m_cks) begin miscompares++; $display("FAIL b2b.checksum got %h want %h", checksum, m_cks); end
`endif
      for (int i = 0; i < 8; i++) begin
         fetch_addr = 32'(4*i);
         tick();
         vectors++;
         if (fetch_instr !== m_fetch) begin miscompares++; $display("FAIL b2b.fetch%0d got %h want %h", 4*i, fetch_instr, m_fetch); end
      end
   endtask

   task test_rst_mid_wr();
      do_reset();
      put_word(32'h11111111, 1'b0);
      drain();
      do_reset();
      put_word(32'hAABBCCDD, 1'b0);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++; if (in_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_wr.rdy_busy got %0b/%0b want 1/0", in_ready, busy); end
      vectors++; if (done !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL rst_wr.flags got %0b/%0b want 0/0", done, overflow); end
      vectors++; if (word_count !== 5'd0 || fetch_instr !== 32'd0) begin miscompares++; $display("FAIL rst_wr.regs got wc=%0d f=%h want 0/0", word_count, fetch_instr); end
      fetch_addr = 32'd0;
      tick();
      vectors++; if (fetch_instr !== 32'hAABB1111) begin miscompares++; $display("FAIL rst_wr.fetch0 got %h want aabb1111", fetch_instr); end
      put_word(32'h55667788, 1'b1);
      drain();
      tick();
      vectors++; if (fetch_instr !== 32'h55667788) begin miscompares++; $display("FAIL rst_wr.restart got %h want 55667788", fetch_instr); end
      vectors++; if (done !== 1'b1 || word_count !== 5'd1) begin miscompares++; $display("FAIL rst_wr.done got %0b wc=%0d want 1/1", done, word_count); end
   endtask

   task test_rbw();
      logic [31:0] w0, w1, w2, w3;
      w0 = $urandom; w1 = $urandom; w2 = $urandom; w3 = $urandom;
      do_reset();
      put_word(w0, 1'b0); drain();
      put_word(w1, 1'b0); drain();
      do_reset();
      put_word(w2, 1'b0); drain();
      put_word(w3, 1'b0);
      fetch_addr = 32'd4;
      tick();
      vectors++; if (fetch_instr !== w1) begin miscompares++; $display("FAIL rbw.old got %h want %h", fetch_instr, w1); end
      tick();
      vectors++; if (fetch_instr !== {w3[31:24], w1[23:0]}) begin miscompares++; $display("FAIL rbw.new got %h want %h", fetch_instr, {w3[31:24], w1[23:0]}); end
      drain();
      tick();
      vectors++; if (fetch_instr !== w3 || fetch_instr !== m_fetch) begin miscompares++; $display("FAIL rbw.final got %h want %h", fetch_instr, w3); end
   endtask

   initial begin
      test_reset();
      test_overflow();
      test_single();
      test_program();
      test_back_to_back();
      test_rst_mid_wr();
      test_rbw();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
